// File: rtl/iurt_fifo_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iurt_fifo_controller - Wishbone register front end for an RX/TX byte FIFO
// pair with debug break. Build macro IURT_IRQ_EN enables irq.     Rev 1.0
// ---------------------------------------------------------------------------
module iurt_fifo_controller #(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        ce,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:2]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        irq,
  output logic        break_o,  // "break" is a reserved word in SystemVerilog
  input  logic        data_dwn_valid,
  input  logic [7:0]  data_dwn,
  output logic        data_dwn_ready,
  input  logic        data_up_ready,
  output logic        data_up_valid,
  output logic [7:0]  data_up
);

  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;

  localparam logic [RX_DEPTH_LOG2:0]   RX_FULL_CNT = (RX_DEPTH_LOG2 + 1)'(RX_DEPTH);
  localparam logic [TX_DEPTH_LOG2:0]   TX_FULL_CNT = (TX_DEPTH_LOG2 + 1)'(TX_DEPTH);
  localparam logic [RX_DEPTH_LOG2:0]   RX_CNT_ONE  = (RX_DEPTH_LOG2 + 1)'(1);
  localparam logic [TX_DEPTH_LOG2:0]   TX_CNT_ONE  = (TX_DEPTH_LOG2 + 1)'(1);
  localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE  = (RX_DEPTH_LOG2)'(1);
  localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE  = (TX_DEPTH_LOG2)'(1);

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_CTRL   = 2'd1;
  localparam logic [1:0] ADR_STATUS = 2'd2;

`ifdef IURT_IRQ_EN
  localparam logic [2:0] CTRL_WR_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_WR_MASK = 3'b001;
`endif

  logic [7:0] rx_mem [RX_DEPTH];
  logic [7:0] tx_mem [TX_DEPTH];

  logic [RX_DEPTH_LOG2-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RX_DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d;
  logic [TX_DEPTH_LOG2-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TX_DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d;

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        up_valid_q, up_valid_d;
  logic [7:0]  up_data_q, up_data_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        ovf_q, ovf_d;
  logic        brk_local_q, brk_local_d;
  logic        irq_q, irq_d;

  logic rx_full, rx_nonempty, tx_full, tx_empty;
  logic req, tx_stall, accept, wr_acc, rd_acc;
  logic rx_push, rx_pop, tx_push, tx_pop, ovf_clr;
  logic [7:0]  rx_head;
  logic [31:0] status;
  logic        unused_dat;

  assign rx_full     = (rx_cnt_q == RX_FULL_CNT);
  assign rx_nonempty = (rx_cnt_q != '0);
  assign tx_full     = (tx_cnt_q == TX_FULL_CNT);
  assign tx_empty    = (tx_cnt_q == '0);
  assign rx_head     = rx_mem[rx_rd_q];

  // A data write into a full TX FIFO is held off; the master keeps strobing.
  assign req      = cyc_i & stb_i & ce & ~ack_q;
  assign tx_stall = we_i & (adr_i == ADR_DATA) & tx_full;
  assign accept   = req & ~tx_stall;
  assign wr_acc   = accept & we_i;
  assign rd_acc   = accept & ~we_i;

  assign rx_push = ce & data_dwn_valid & ~rx_full;
  assign rx_pop  = rd_acc & (adr_i == ADR_DATA) & rx_nonempty;
  assign tx_push = wr_acc & (adr_i == ADR_DATA);
  assign tx_pop  = ce & data_up_ready & ~tx_empty;
  assign ovf_clr = wr_acc & (adr_i == ADR_STATUS) & dat_i[3];

  assign status = {8'(rx_cnt_q), 8'(tx_cnt_q), 12'b0,
                   ovf_q, tx_full, tx_empty, rx_nonempty};

  assign unused_dat = ^dat_i[31:8];

  always_comb begin
    rx_wr_d     = rx_wr_q;
    rx_rd_d     = rx_rd_q;
    rx_cnt_d    = rx_cnt_q;
    tx_wr_d     = tx_wr_q;
    tx_rd_d     = tx_rd_q;
    tx_cnt_d    = tx_cnt_q;
    ack_d       = ack_q;
    dat_d       = dat_q;
    up_valid_d  = up_valid_q;
    up_data_d   = up_data_q;
    ctrl_d      = ctrl_q;
    ovf_d       = ovf_q;
    brk_local_d = brk_local_q;
    irq_d       = irq_q;

    if (ce) begin
      ack_d = accept;

      if (rx_push) rx_wr_d = rx_wr_q + RX_PTR_ONE;
      if (rx_pop)  rx_rd_d = rx_rd_q + RX_PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_d = rx_cnt_q + RX_CNT_ONE;
        2'b01:   rx_cnt_d = rx_cnt_q - RX_CNT_ONE;
        default: rx_cnt_d = rx_cnt_q;
      endcase

      if (tx_push) tx_wr_d = tx_wr_q + TX_PTR_ONE;
      if (tx_pop)  tx_rd_d = tx_rd_q + TX_PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_d = tx_cnt_q + TX_CNT_ONE;
        2'b01:   tx_cnt_d = tx_cnt_q - TX_CNT_ONE;
        default: tx_cnt_d = tx_cnt_q;
      endcase

      up_valid_d = tx_pop;
      if (tx_pop) up_data_d = tx_mem[tx_rd_q];

      // A new overflow wins over a simultaneous clear.
      ovf_d = (ovf_q & ~ovf_clr) | (data_dwn_valid & rx_full);

      brk_local_d = data_dwn_valid;
      if (break_o) ctrl_d[0] = 1'b0;
      if (wr_acc && adr_i == ADR_CTRL) ctrl_d = dat_i[2:0] & CTRL_WR_MASK;

      if (rd_acc) begin
        case (adr_i)
          ADR_DATA:   dat_d = {23'b0, rx_nonempty, rx_nonempty ? rx_head : 8'h00};
          ADR_CTRL:   dat_d = {29'b0, ctrl_q};
          ADR_STATUS: dat_d = status;
          default:    dat_d = 32'h0;
        endcase
      end else if (wr_acc) begin
        dat_d = 32'h0;
      end

`ifdef IURT_IRQ_EN
      irq_d = (ctrl_d[1] & (rx_cnt_d != '0)) | (ctrl_d[2] & (tx_cnt_d == '0)) | ovf_d;
`else
      irq_d = 1'b0;
`endif
    end
  end

  // Storage carries no reset; contents behind reset pointers are don't-care.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= data_dwn;
    if (tx_push) tx_mem[tx_wr_q] <= dat_i[7:0];
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      rx_cnt_q    <= '0;
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      tx_cnt_q    <= '0;
      ack_q       <= 1'b0;
      dat_q       <= 32'h0;
      up_valid_q  <= 1'b0;
      up_data_q   <= 8'h00;
      ctrl_q      <= 3'b001;
      ovf_q       <= 1'b0;
      brk_local_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_wr_q     <= tx_wr_d;
      tx_rd_q     <= tx_rd_d;
      tx_cnt_q    <= tx_cnt_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      up_valid_q  <= up_valid_d;
      up_data_q   <= up_data_d;
      ctrl_q      <= ctrl_d;
      ovf_q       <= ovf_d;
      brk_local_q <= brk_local_d;
      irq_q       <= irq_d;
    end
  end

  assign ack_o          = ack_q;
  assign dat_o          = dat_q;
  assign data_up_valid  = up_valid_q;
  assign data_up        = up_data_q;
  assign data_dwn_ready = ~rx_full;
  assign break_o        = brk_local_q & ctrl_q[0];
  assign irq            = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_iurt_fifo_controller.sv
`default_nettype none
// Testbench for iurt_fifo_controller: queue-based reference model plus
// directed scenarios with literal expectations and randomized traffic.
module tb_iurt_fifo_controller;

  localparam int RXD = 16;
  localparam int TXD = 16;

  logic        clk = 1'b0;
  logic        arst, ce, cyc_i, stb_i, we_i;
  logic [1:0]  adr_i;
  logic [31:0] dat_i, dat_o;
  logic        ack_o, irq, break_o;
  logic        data_dwn_valid, data_dwn_ready, data_up_ready, data_up_valid;
  logic [7:0]  data_dwn, data_up;

  int n_cmp = 0;
  int n_bad = 0;

  iurt_fifo_controller #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4)) dut (
    .clk(clk), .arst(arst), .ce(ce),
    .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
    .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
    .irq(irq), .break_o(break_o),
    .data_dwn_valid(data_dwn_valid), .data_dwn(data_dwn), .data_dwn_ready(data_dwn_ready),
    .data_up_ready(data_up_ready), .data_up_valid(data_up_valid), .data_up(data_up)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic        m_ack, m_dat_rd, m_upv, m_ovf, m_bl, m_irq;
  logic [31:0] m_dat;
  logic [7:0]  m_upd;
  logic [2:0]  m_ctrl;

`ifdef IURT_IRQ_EN
  localparam logic [2:0] MASK = 3'b111;
`else
  localparam logic [2:0] MASK = 3'b001;
`endif

  function automatic void model_reset();
    rx_q.delete(); tx_q.delete();
    m_ack = 0; m_dat_rd = 0; m_upv = 0; m_ovf = 0; m_bl = 0; m_irq = 0;
    m_dat = 0; m_upd = 0; m_ctrl = 3'b001;
  endfunction

  function automatic logic [31:0] model_status();
    return (32'(rx_q.size()) << 24) | (32'(tx_q.size()) << 16) |
           (32'(m_ovf) << 3) | (32'(tx_q.size() == TXD) << 2) |
           (32'(tx_q.size() == 0) << 1) | 32'(rx_q.size() != 0);
  endfunction

  function automatic void model_step();
    logic acc, brk;
    int   pre_rx, pre_tx;
    if (arst) begin model_reset(); return; end
    if (!ce) return;
    acc    = cyc_i && stb_i && !m_ack && !(we_i && adr_i == 0 && tx_q.size() == TXD);
    brk    = m_bl && m_ctrl[0];
    pre_rx = rx_q.size();
    pre_tx = tx_q.size();
    if (acc && !we_i) begin
      m_dat_rd = 1;
      case (adr_i)
        2'd0:    m_dat = (pre_rx > 0) ? (32'h100 | 32'(rx_q[0])) : 32'h0;
        2'd1:    m_dat = 32'(m_ctrl);
        2'd2:    m_dat = model_status();
        default: m_dat = 32'h0;
      endcase
    end else if (acc) begin
      m_dat_rd = 0;
    end
    if (acc && !we_i && adr_i == 0 && pre_rx > 0) void'(rx_q.pop_front());
    if (acc && we_i && adr_i == 2 && dat_i[3]) m_ovf = 0;
    if (data_dwn_valid) begin
      if (pre_rx < RXD) rx_q.push_back(data_dwn);
      else m_ovf = 1;
    end
    if (data_up_ready && pre_tx > 0) begin m_upv = 1; m_upd = tx_q.pop_front(); end
    else m_upv = 0;
    if (acc && we_i && adr_i == 0) tx_q.push_back(dat_i[7:0]);
    if (brk) m_ctrl[0] = 0;
    if (acc && we_i && adr_i == 1) m_ctrl = dat_i[2:0] & MASK;
    m_bl  = data_dwn_valid;
    m_ack = acc;
`ifdef IURT_IRQ_EN
    m_irq = (m_ctrl[1] && rx_q.size() != 0) || (m_ctrl[2] && tx_q.size() == 0) || m_ovf;
`else
    m_irq = 0;
`endif
  endfunction

  always begin
    @(posedge clk);
    model_step();
    #1;
    check("ack", ack_o, m_ack);
    check("dwn_ready", data_dwn_ready, rx_q.size() != RXD);
    check("up_valid", data_up_valid, m_upv);
    if (m_upv) check("up_data", data_up, m_upd);
    check("break", break_o, m_bl & m_ctrl[0]);
    check("irq", irq, m_irq);
    if (m_ack && m_dat_rd) check("rdata", dat_o, m_dat);
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input bit keep_bus);
    @(negedge clk);
    arst = 1; ce = 1; data_dwn_valid = 0; data_up_ready = 0;
    if (!keep_bus) begin cyc_i = 0; stb_i = 0; we_i = 0; end
    #1;
    check("rst_ack", ack_o, 0);
    check("rst_up_valid", data_up_valid, 0);
    check("rst_up_data", data_up, 0);
    check("rst_break", break_o, 0);
    check("rst_irq", irq, 0);
    check("rst_dwn_ready", data_dwn_ready, 1);
    repeat (2) @(negedge clk);
    cyc_i = 0; stb_i = 0; we_i = 0;
    arst = 0;
  endtask

  task automatic wb(input logic we, input logic [1:0] adr, input logic [31:0] wd,
                    output logic [31:0] rd);
    logic got;
    int   n;
    @(negedge clk);
    cyc_i = 1; stb_i = 1; we_i = we; adr_i = adr; dat_i = wd;
    got = 0; n = 0; rd = 32'h0;
    while (!got && n < 50) begin
      @(posedge clk); #1;
      got = ack_o; rd = dat_o; n++;
    end
    @(negedge clk);
    cyc_i = 0; stb_i = 0; we_i = 0;
    check("wb_ack_within_bound", got, 1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    data_dwn_valid = 1; data_dwn = b;
    @(negedge clk);
    data_dwn_valid = 0;
  endtask

  logic [31:0] rd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1; ce = 1; cyc_i = 0; stb_i = 0; we_i = 0; adr_i = 0; dat_i = 0;
    data_dwn_valid = 0; data_dwn = 0; data_up_ready = 0;

    // Two bytes down, read back in order, then an empty read.
    do_reset(0);
    push_byte(8'h41);
    push_byte(8'h42);
    wb(0, 2'd0, 0, rd); check("rx_read1", rd, 32'h141);
    wb(0, 2'd0, 0, rd); check("rx_read2", rd, 32'h142);
    wb(0, 2'd0, 0, rd); check("rx_read_empty", rd, 32'h000);

    // Fill TX, stall the 17th write, then drain.
    do_reset(0);
    for (int i = 0; i < 16; i++) wb(1, 2'd0, 32'h10 + i, rd);
    wb(0, 2'd2, 0, rd); check("tx_full_status", rd, 32'h0010_0004);
    @(negedge clk);
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 0; dat_i = 32'h99;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; check("stall_no_ack", ack_o, 0); end
    @(negedge clk);
    data_up_ready = 1;
    @(posedge clk); #1;
    check("first_drain", {data_up_valid, data_up}, {1'b1, 8'h10});
    begin
      int n = 0;
      while (!ack_o && n < 10) begin @(posedge clk); #1; n++; end
      check("stalled_write_acks", ack_o, 1);
    end
    @(negedge clk);
    cyc_i = 0; stb_i = 0; we_i = 0;
    repeat (25) @(negedge clk);
    wb(0, 2'd2, 0, rd); check("tx_drained_status", rd, 32'h0000_0002);

    // RX overflow and its clear.
    do_reset(0);
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin data_dwn_valid = 1; data_dwn = 8'(i); @(negedge clk); end
    data_dwn_valid = 0;
    check("rx_full_not_ready", data_dwn_ready, 0);
    wb(0, 2'd2, 0, rd); check("overflow_status", rd, 32'h1000_000B);
    wb(1, 2'd2, 32'h8, rd);
    wb(0, 2'd2, 0, rd); check("overflow_cleared", rd, 32'h1000_0003);

    // Break: single-cycle pulse, self-clear, re-arm.
    do_reset(0);
    @(negedge clk);
    data_dwn_valid = 1;
    @(negedge clk); data_dwn_valid = 0; check("break_first", break_o, 1);
    @(negedge clk); check("break_one_cycle", break_o, 0);
    data_dwn_valid = 1;
    @(negedge clk); data_dwn_valid = 0; check("break_disarmed", break_o, 0);
    @(negedge clk); check("break_disarmed2", break_o, 0);
    wb(1, 2'd1, 32'h1, rd);
    data_dwn_valid = 1;
    @(negedge clk); data_dwn_valid = 0; check("break_rearmed", break_o, 1);

    // Interrupt and reset during a stalled write.
    do_reset(0);
    wb(1, 2'd1, 32'h3, rd);
    wb(0, 2'd1, 0, rd);
`ifdef IURT_IRQ_EN
    check("ctrl_readback", rd, 32'h3);
`else
    check("ctrl_readback", rd, 32'h1);
`endif
    push_byte(8'h5A);
`ifdef IURT_IRQ_EN
    check("irq_on_rx", irq, 1);
`else
    check("irq_on_rx", irq, 0);
`endif
    wb(0, 2'd0, 0, rd); check("irq_read_byte", rd, 32'h15A);
    check("irq_after_read", irq, 0);
    for (int i = 0; i < 16; i++) wb(1, 2'd0, 32'hA0 + i, rd);
    @(negedge clk);
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 0; dat_i = 32'h77;
    repeat (3) @(negedge clk);
    do_reset(1);
    repeat (3) begin @(posedge clk); #1; check("no_ack_after_abort", ack_o, 0); end
    wb(0, 2'd2, 0, rd); check("status_after_abort", rd, 32'h0000_0002);

    // Randomized traffic, all outputs checked by the model every cycle.
    for (int seg = 0; seg < 6; seg++) begin
      int p_req = $urandom_range(10, 80);
      int p_dv  = $urandom_range(5, 90);
      int p_ur  = $urandom_range(5, 90);
      int p_we  = $urandom_range(20, 80);
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        arst           = ($urandom_range(0, 399) == 0);
        ce             = ($urandom_range(0, 99) < 90);
        cyc_i          = ($urandom_range(0, 99) < p_req);
        stb_i          = cyc_i ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1));
        we_i           = ($urandom_range(0, 99) < p_we);
        adr_i          = 2'($urandom_range(0, 3));
        dat_i          = $urandom;
        data_dwn_valid = ($urandom_range(0, 99) < p_dv);
        data_dwn       = 8'($urandom);
        data_up_ready  = ($urandom_range(0, 99) < p_ur);
      end
    end
    @(negedge clk);
    arst = 0; ce = 1; cyc_i = 0; stb_i = 0; we_i = 0; data_dwn_valid = 0; data_up_ready = 0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
